// File: rtl/sonar_pkg.sv
// Shared sonar definitions: FSM state encodings and 50 MHz timing constants
// used by the HC-SR04 emulator and the sonar's own distance measurement.
package sonar_pkg;

    localparam logic [2:0] ST_OCIOSO    = 3'd0;
    localparam logic [2:0] ST_MEDE_TRIG = 3'd1;
    localparam logic [2:0] ST_ATRASO    = 3'd2;
    localparam logic [2:0] ST_ECHO      = 3'd3;
    localparam logic [2:0] ST_RECUPERA  = 3'd4;

    localparam int SONAR_TRIG_MIN      = 500;
    localparam int SONAR_CICLOS_POR_CM = 2941;
    localparam int SONAR_TIMEOUT       = 1900000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the output is
// cleared by the synchronous reset.
module sincronizador_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sinc_q, sinc_d;

    // Next values of the two synchronizer stages
    always_comb begin
        meta_d = d;
        sinc_d = meta_q;
    end

    // Synchronizer registers
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sinc_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sinc_q <= sinc_d;
        end
    end

    assign q = sinc_q;

endmodule

// File: rtl/emulador_hcsr04.sv
// HC-SR04 responder: validates the trigger pulse, waits the acoustic latency and
// returns an echo whose width encodes the latched distance.
module emulador_hcsr04
    import sonar_pkg::*;
#(
    parameter int TRIG_MIN_CICLOS = SONAR_TRIG_MIN,
    parameter int ATRASO_CICLOS   = 25000,
    parameter int CICLOS_POR_CM   = SONAR_CICLOS_POR_CM,
    parameter int DIST_MIN_CM     = 2,
    parameter int DIST_MAX_CM     = 400,
    parameter int TIMEOUT_CICLOS  = SONAR_TIMEOUT,
    parameter int RECUPERA_CICLOS = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] distancia_cm,
    input  logic       sem_obstaculo,
    output logic       echo,
    output logic       ocupado,
    output logic       erro_trigger,
    output logic [2:0] db_estado
);

    localparam int CW = $clog2(max2(max2(TIMEOUT_CICLOS, DIST_MAX_CM * CICLOS_POR_CM),
                                    max2(RECUPERA_CICLOS, ATRASO_CICLOS))) + 1;

    localparam logic [CW-1:0] TRIG_MIN_C   = CW'(TRIG_MIN_CICLOS);
    localparam logic [CW-1:0] ATRASO_FIM   = CW'(ATRASO_CICLOS - 1);
    localparam logic [CW-1:0] RECUPERA_FIM = CW'(RECUPERA_CICLOS - 1);
    localparam logic [CW-1:0] TIMEOUT_W    = CW'(TIMEOUT_CICLOS);
    localparam logic [CW-1:0] POR_CM_W     = CW'(CICLOS_POR_CM);
    localparam logic [8:0]    DIST_MIN_W   = 9'(DIST_MIN_CM);
    localparam logic [8:0]    DIST_MAX_W   = 9'(DIST_MAX_CM);

    logic          trig_s, sobe_s, desce_s;
    logic          trig_ant_q, trig_ant_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    dist_q, dist_d;
    logic          sem_q, sem_d;
    logic          echo_q, echo_d;
    logic          ocupado_q, ocupado_d;
    logic          erro_q, erro_d;
    logic [8:0]    dist_clamp_s;
    logic [CW-1:0] largura_s;

    sincronizador_2ff u_sinc_trigger (
        .clock (clock),
        .reset (reset),
        .d     (trigger),
        .q     (trig_s)
    );

    assign sobe_s  = trig_s & ~trig_ant_q;
    assign desce_s = ~trig_s & trig_ant_q;

    // Echo width from the latched distance; the product is formed at counter width
    always_comb begin
        if (dist_q < DIST_MIN_W) begin
            dist_clamp_s = DIST_MIN_W;
        end else if (dist_q > DIST_MAX_W) begin
            dist_clamp_s = DIST_MAX_W;
        end else begin
            dist_clamp_s = dist_q;
        end
        if (sem_q) begin
            largura_s = TIMEOUT_W;
        end else begin
            largura_s = CW'(dist_clamp_s) * POR_CM_W;
        end
    end

    // FSM next state, shared counter and distance latch
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dist_d     = dist_q;
        sem_d      = sem_q;
        erro_d     = 1'b0;
        trig_ant_d = trig_s;
        case (state_q)
            ST_OCIOSO: begin
                if (sobe_s) begin
                    state_d = ST_MEDE_TRIG;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_MEDE_TRIG: begin
                if (desce_s) begin
                    cnt_d = '0;
                    if (cnt_q >= TRIG_MIN_C) begin
                        dist_d  = distancia_cm;
                        sem_d   = sem_obstaculo;
                        state_d = ST_ATRASO;
                    end else begin
                        erro_d  = 1'b1;
                        state_d = ST_OCIOSO;
                    end
                end else if (trig_s && (cnt_q < TRIG_MIN_C)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ATRASO: begin
                if (cnt_q == ATRASO_FIM) begin
                    state_d = ST_ECHO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ECHO: begin
                if (cnt_q == (largura_s - CW'(1))) begin
                    state_d = ST_RECUPERA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RECUPERA: begin
                if (cnt_q == RECUPERA_FIM) begin
                    state_d = ST_OCIOSO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_OCIOSO;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs follow the state one edge later, which fixes the echo latency
    always_comb begin
        echo_d    = (state_q == ST_ECHO);
        ocupado_d = (state_q != ST_OCIOSO);
    end

    // State, counter, latch and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_OCIOSO;
            cnt_q      <= '0;
            dist_q     <= 9'd0;
            sem_q      <= 1'b0;
            trig_ant_q <= 1'b0;
            echo_q     <= 1'b0;
            ocupado_q  <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dist_q     <= dist_d;
            sem_q      <= sem_d;
            trig_ant_q <= trig_ant_d;
            echo_q     <= echo_d;
            ocupado_q  <= ocupado_d;
            erro_q     <= erro_d;
        end
    end

    assign echo         = echo_q;
    assign ocupado      = ocupado_q;
    assign erro_trigger = erro_q;
    assign db_estado    = state_q;

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Directed bench for emulador_hcsr04 with reduced timing parameters.
module tb_emulador_hcsr04;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b0;
    logic [8:0] distancia_cm = 9'd0;
    logic       sem_obstaculo = 1'b0;
    logic       echo, ocupado, erro_trigger;
    logic [2:0] db_estado;

    int n_assert = 0;
    int n_fail   = 0;
    int n_erro   = 0;
    int n_rises  = 0;
    logic echo_prev = 1'b0;

    emulador_hcsr04 #(
        .TRIG_MIN_CICLOS (5),
        .ATRASO_CICLOS   (10),
        .CICLOS_POR_CM   (3),
        .DIST_MIN_CM     (2),
        .DIST_MAX_CM     (400),
        .TIMEOUT_CICLOS  (2000),
        .RECUPERA_CICLOS (20)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .trigger       (trigger),
        .distancia_cm  (distancia_cm),
        .sem_obstaculo (sem_obstaculo),
        .echo          (echo),
        .ocupado       (ocupado),
        .erro_trigger  (erro_trigger),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (erro_trigger === 1'b1) n_erro <= n_erro + 1;
        if (echo === 1'b1 && echo_prev === 1'b0) n_rises <= n_rises + 1;
        echo_prev <= echo;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic pulse(input int len);
        trigger = 1'b1;
        repeat (len) tick();
        trigger = 1'b0;
    endtask

    // Valid trigger then measure latency from edge 0, echo width and echo-fall to idle gap
    task automatic run_echo(input logic [8:0] d, input logic s, input int tl, input bit mexe,
                            output int lat, output int width, output int gap);
        distancia_cm  = d;
        sem_obstaculo = s;
        pulse(tl);
        lat = -1;
        do begin
            tick();
            lat++;
        end while (echo !== 1'b1 && lat < 100);
        width = 0;
        while (echo === 1'b1 && width < 5000) begin
            width++;
            if (mexe && width == 100) begin
                sem_obstaculo = 1'b0;
                distancia_cm  = 9'd7;
            end
            tick();
        end
        gap = 0;
        while (ocupado === 1'b1 && gap < 100) begin
            tick();
            gap++;
        end
        repeat (2) tick();
    endtask

    initial begin
        int lat, width, gap, e0, r0;

        repeat (3) tick();
        check("reset_echo", int'(echo), 0);
        check("reset_ocupado", int'(ocupado), 0);
        check("reset_erro", int'(erro_trigger), 0);
        check("reset_estado", int'(db_estado), 0);
        reset = 1'b0;
        repeat (2) tick();

        // Nominal
        run_echo(9'd100, 1'b0, 8, 1'b0, lat, width, gap);
        check("nom_latency", lat, 13);
        check("nom_width", width, 300);
        check("nom_ocupado_gap", gap, 20);
        check("nom_idle_estado", int'(db_estado), 0);

        // Short trigger
        e0 = n_erro;
        r0 = n_rises;
        pulse(3);
        repeat (15) tick();
        check("short_erro_cycles", n_erro - e0, 1);
        check("short_no_echo", n_rises - r0, 0);
        check("short_estado", int'(db_estado), 0);
        check("short_ocupado", int'(ocupado), 0);

        // Clamping
        run_echo(9'd0, 1'b0, 6, 1'b0, lat, width, gap);
        check("clamp_min_width", width, 6);
        run_echo(9'd511, 1'b0, 6, 1'b0, lat, width, gap);
        check("clamp_max_width", width, 1200);

        // No obstacle, inputs changed mid-echo
        run_echo(9'd50, 1'b1, 6, 1'b1, lat, width, gap);
        check("timeout_width", width, 2000);
        check("timeout_latency", lat, 13);

        // Retrigger during ATRASO, ECHO and RECUPERA
        e0 = n_erro;
        r0 = n_rises;
        distancia_cm  = 9'd20;
        sem_obstaculo = 1'b0;
        pulse(6);
        repeat (3) tick();
        check("retrig_atraso_estado", int'(db_estado), 2);
        pulse(6);
        gap = 0;
        while (echo !== 1'b1 && gap < 100) begin
            tick();
            gap++;
        end
        check("retrig_echo_seen", int'(echo), 1);
        repeat (10) tick();
        pulse(6);
        gap = 0;
        while (echo === 1'b1 && gap < 200) begin
            tick();
            gap++;
        end
        check("retrig_recupera_estado", int'(db_estado), 4);
        repeat (3) tick();
        pulse(6);
        gap = 0;
        while (ocupado === 1'b1 && gap < 100) begin
            tick();
            gap++;
        end
        repeat (3) tick();
        check("retrig_no_erro", n_erro - e0, 0);
        check("retrig_one_echo", n_rises - r0, 1);
        run_echo(9'd20, 1'b0, 6, 1'b0, lat, width, gap);
        check("retrig_new_latency", lat, 13);
        check("retrig_new_width", width, 60);

        // Reset at echo cycle 50
        distancia_cm = 9'd100;
        pulse(6);
        gap = 0;
        while (echo !== 1'b1 && gap < 100) begin
            tick();
            gap++;
        end
        repeat (49) tick();
        check("rst_pre_echo", int'(echo), 1);
        reset = 1'b1;
        tick();
        check("rst_echo", int'(echo), 0);
        check("rst_estado", int'(db_estado), 0);
        check("rst_ocupado", int'(ocupado), 0);
        reset = 1'b0;
        repeat (2) tick();
        run_echo(9'd10, 1'b0, 6, 1'b0, lat, width, gap);
        check("post_rst_latency", lat, 13);
        check("post_rst_width", width, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
